// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor
// Description : Bridges whole cache lines to a beat-wide burst memory port,
//               handling line fills (reads) and writebacks (writes).
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,

  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int n_beats = s_line / s_burst;
  localparam int c_cnt_w = $clog2(n_beats);
  localparam int c_offs  = $clog2(s_line / 8);

  localparam logic [31:0]        c_addr_mask = ~((32'd1 << c_offs) - 32'd1);
  localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(n_beats - 1);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RD_BEAT = 2'd1;
  localparam logic [1:0] c_WR_BEAT = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [s_line-1:0]  r_wr_line;
  logic [s_burst-1:0] r_fill [n_beats];
  logic [s_burst-1:0] w_wr_beat [n_beats];
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_rd_ack;
  logic               w_wr_ack;

  assign w_cnt_nxt = r_cnt + c_one;
  assign w_rd_ack  = (r_state == c_RD_BEAT) && resp_i;
  assign w_wr_ack  = (r_state == c_WR_BEAT) && resp_i;

  // Each beat slot of the filled line is its own register so that only the
  // addressed slot loads; the rest hold across gaps and between reads.
  generate
    for (genvar b = 0; b < n_beats; b++) begin : g_beat
      assign w_wr_beat[b] = r_wr_line[b*s_burst +: s_burst];
      assign line_o[b*s_burst +: s_burst] = r_fill[b];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_fill[b] <= '0;
        end else if (w_rd_ack && (r_cnt == c_cnt_w'(b))) begin
          r_fill[b] <= burst_i;
        end
      end
    end
  endgenerate

  // Outputs are loaded alongside the state transition so they line up with
  // the state they belong to while staying purely registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_wr_line <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          resp_o <= 1'b0;
          if (write_i) begin
            r_state   <= c_WR_BEAT;
            r_cnt     <= '0;
            r_wr_line <= line_i;
            burst_o   <= line_i[s_burst-1:0];
            address_o <= address_i & c_addr_mask;
            write_o   <= 1'b1;
          end else if (read_i) begin
            r_state   <= c_RD_BEAT;
            r_cnt     <= '0;
            address_o <= address_i & c_addr_mask;
            read_o    <= 1'b1;
          end
        end

        c_RD_BEAT: begin
          if (w_rd_ack) begin
            if (r_cnt == c_last) begin
              r_state <= c_DONE;
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end

        c_WR_BEAT: begin
          if (w_wr_ack) begin
            if (r_cnt == c_last) begin
              r_state <= c_DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_nxt;
              burst_o <= w_wr_beat[w_cnt_nxt];
            end
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          resp_o  <= 1'b0;
        end

        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          read_o  <= 1'b0;
          write_o <= 1'b0;
          resp_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
